cdb_arbiter: RTL and testbench

Common-data-bus arbiter between the ALU and LSB result ports and every broadcast consumer: dispatcher operand bypass, RS, LSB, ROB. It buffers each source's results in a small FIFO and grants one result per cycle, using round-robin when both sources hold data. It drives a single registered broadcast `cdb_*`, so consumers compare against one tag instead of two. On a mispredict flush it discards all buffered results.

---
 rtl/cdb_arbiter_pkg.sv | 25 ++
 rtl/cdb_arbiter_if.sv | 34 +++
 rtl/cdb_arbiter_result_fifo.sv | 50 +++++
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 tb/tb_cdb_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common-data-bus arbiter.
// Tag 0 is reserved to mean "no producer" across the dispatcher, RS, LSB and ROB.
package cdb_arbiter_pkg;

  localparam int CDB_DATA_W     = 32;
  localparam int CDB_ROB_ID_W   = 5;
  localparam int CDB_FIFO_DEPTH = 2;
  localparam int NULL_ROB_ID    = 0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  // Round-robin pick: on a tie the source that did not win last time goes first.
  function automatic cdb_src_e pick_src(input logic alu_cand, input logic lsb_cand,
                                        input cdb_src_e last_grant);
    cdb_src_e win;
    if (alu_cand && lsb_cand) win = (last_grant == SRC_ALU) ? SRC_LSB : SRC_ALU;
    else if (alu_cand)        win = SRC_ALU;
    else                      win = SRC_LSB;
    return win;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result ports of both producers plus the single broadcast bus seen by all consumers.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W   = CDB_DATA_W,
  parameter int ROB_ID_W = CDB_ROB_ID_W
);

  logic                alu_valid;
  logic [DATA_W-1:0]   alu_res;
  logic [ROB_ID_W-1:0] alu_rob_id;
  logic                alu_full;

  logic                lsb_valid;
  logic [DATA_W-1:0]   lsb_res;
  logic [ROB_ID_W-1:0] lsb_rob_id;
  logic                lsb_full;

  logic                cdb_valid;
  logic [DATA_W-1:0]   cdb_res;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic                cdb_src;

  modport slave (
    input  alu_valid, alu_res, alu_rob_id, lsb_valid, lsb_res, lsb_rob_id,
    output alu_full, lsb_full, cdb_valid, cdb_res, cdb_rob_id, cdb_src
  );

  modport master (
    output alu_valid, alu_res, alu_rob_id, lsb_valid, lsb_res, lsb_rob_id,
    input  alu_full, lsb_full, cdb_valid, cdb_res, cdb_rob_id, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-source result buffer: wrap-around pointers with a separate occupancy count.
// Callers never push while full or pop while empty.
module cdb_arbiter_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers ALU and LSB results and broadcasts one per cycle
// on a registered bus, round-robin between the two sources.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W     = CDB_DATA_W,
  parameter int ROB_ID_W   = CDB_ROB_ID_W,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  localparam int ENT_W = DATA_W + ROB_ID_W;

  logic             live;
  logic             alu_acc, lsb_acc;
  logic             alu_empty, lsb_empty;
  logic             alu_full_w, lsb_full_w;
  logic [ENT_W-1:0] alu_head, lsb_head;
  logic [ENT_W-1:0] alu_in, lsb_in;
  logic [ENT_W-1:0] alu_ent, lsb_ent, win_ent;
  logic             alu_cand, lsb_cand, any_grant;
  logic             grant_alu, grant_lsb;
  logic             alu_push, alu_pop, lsb_push, lsb_pop;
  logic             fifo_clear;
  cdb_src_e         win;
  cdb_src_e         last_grant;

  logic                cdb_valid_q;
  logic [DATA_W-1:0]   cdb_res_q;
  logic [ROB_ID_W-1:0] cdb_rob_id_q;
  cdb_src_e            cdb_src_q;

  assign live       = rdy & ~flush;
  assign fifo_clear = rdy & flush;

  // Valid while full is a producer protocol error; such inputs are dropped.
  assign alu_acc = live & bus.alu_valid & ~alu_full_w &
                   (bus.alu_rob_id != ROB_ID_W'(NULL_ROB_ID));
  assign lsb_acc = live & bus.lsb_valid & ~lsb_full_w &
                   (bus.lsb_rob_id != ROB_ID_W'(NULL_ROB_ID));

  assign alu_in = {bus.alu_res, bus.alu_rob_id};
  assign lsb_in = {bus.lsb_res, bus.lsb_rob_id};

  // An empty FIFO lets the incoming result bypass straight to the grant.
  assign alu_cand = ~alu_empty | alu_acc;
  assign lsb_cand = ~lsb_empty | lsb_acc;
  assign alu_ent  = alu_empty ? alu_in : alu_head;
  assign lsb_ent  = lsb_empty ? lsb_in : lsb_head;

  assign any_grant = live & (alu_cand | lsb_cand);
  assign win       = pick_src(alu_cand, lsb_cand, last_grant);
  assign grant_alu = any_grant & (win == SRC_ALU);
  assign grant_lsb = any_grant & (win == SRC_LSB);
  assign win_ent   = (win == SRC_ALU) ? alu_ent : lsb_ent;

  assign alu_pop  = grant_alu & ~alu_empty;
  assign lsb_pop  = grant_lsb & ~lsb_empty;
  assign alu_push = alu_acc & ~(grant_alu & alu_empty);
  assign lsb_push = lsb_acc & ~(grant_lsb & lsb_empty);

  cdb_arbiter_result_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .push  (alu_push),
    .pop   (alu_pop),
    .din   (alu_in),
    .head  (alu_head),
    .empty (alu_empty),
    .full  (alu_full_w)
  );

  cdb_arbiter_result_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .push  (lsb_push),
    .pop   (lsb_pop),
    .din   (lsb_in),
    .head  (lsb_head),
    .empty (lsb_empty),
    .full  (lsb_full_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q  <= 1'b0;
      cdb_res_q    <= '0;
      cdb_rob_id_q <= '0;
      cdb_src_q    <= SRC_ALU;
      last_grant   <= SRC_LSB;
    end else if (rdy) begin
      if (flush) begin
        cdb_valid_q <= 1'b0;
        last_grant  <= SRC_LSB;
      end else if (any_grant) begin
        cdb_valid_q  <= 1'b1;
        cdb_res_q    <= win_ent[ENT_W-1:ROB_ID_W];
        cdb_rob_id_q <= win_ent[ROB_ID_W-1:0];
        cdb_src_q    <= win;
        last_grant   <= win;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alu_full   = alu_full_w;
  assign bus.lsb_full   = lsb_full_w;
  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_res    = cdb_res_q;
  assign bus.cdb_rob_id = cdb_rob_id_q;
  assign bus.cdb_src    = (cdb_src_q == SRC_LSB);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, then random traffic against a queue model.
module tb_cdb_arbiter;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst, rdy, flush;
  int   n_cmp = 0;
  int   n_fail = 0;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, flush, av;
    logic [4:0]  aid;
    logic [31:0] ares;
    logic        lv;
    logic [4:0]  lid;
    logic [31:0] lres;
  } in_t;

  typedef struct {
    in_t         i;
    logic        ev;
    logic [4:0]  eid;
    logic [31:0] eres;
    logic        esrc, eaf, elf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  id;
  } ent_t;

  vec_t tbl[$];

  // Reference model: one queue per source holds every accepted but unbroadcast result.
  ent_t        mq_a[$];
  ent_t        mq_l[$];
  logic        m_lg;
  logic        m_cv;
  logic [31:0] m_res;
  logic [4:0]  m_id;
  logic        m_src;

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.alu_valid && bus.alu_full))
      else begin $display("FAIL protocol: alu_valid while alu_full"); n_fail++; end
      assert (!(bus.lsb_valid && bus.lsb_full))
      else begin $display("FAIL protocol: lsb_valid while lsb_full"); n_fail++; end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input in_t s);
    logic a_acc, l_acc, a_c, l_c, w;
    ent_t e;
    if (s.rst) begin
      mq_a.delete(); mq_l.delete();
      m_lg = 1'b1; m_cv = 1'b0; m_res = '0; m_id = '0; m_src = 1'b0;
    end else if (s.rdy) begin
      if (s.flush) begin
        mq_a.delete(); mq_l.delete();
        m_cv = 1'b0; m_lg = 1'b1;
      end else begin
        a_acc = s.av && (s.aid != 0) && (mq_a.size() < DEPTH);
        l_acc = s.lv && (s.lid != 0) && (mq_l.size() < DEPTH);
        if (a_acc) mq_a.push_back('{res: s.ares, id: s.aid});
        if (l_acc) mq_l.push_back('{res: s.lres, id: s.lid});
        a_c = (mq_a.size() > 0);
        l_c = (mq_l.size() > 0);
        w = (a_c && l_c) ? ~m_lg : l_c;
        if (a_c || l_c) begin
          e = w ? mq_l.pop_front() : mq_a.pop_front();
          m_cv = 1'b1; m_res = e.res; m_id = e.id; m_src = w; m_lg = w;
        end else begin
          m_cv = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input in_t s);
    @(negedge clk);
    rst = s.rst; rdy = s.rdy; flush = s.flush;
    bus.alu_valid = s.av; bus.alu_rob_id = s.aid; bus.alu_res = s.ares;
    bus.lsb_valid = s.lv; bus.lsb_rob_id = s.lid; bus.lsb_res = s.lres;
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic rd, input logic fl,
                     input logic av, input int aid, input logic [31:0] ares,
                     input logic lv, input int lid, input logic [31:0] lres,
                     input logic ev, input int eid, input logic [31:0] eres,
                     input logic esrc, input logic eaf, input logic elf);
    vec_t v;
    v.i.rst = r; v.i.rdy = rd; v.i.flush = fl;
    v.i.av = av; v.i.aid = 5'(aid); v.i.ares = ares;
    v.i.lv = lv; v.i.lid = 5'(lid); v.i.lres = lres;
    v.ev = ev; v.eid = 5'(eid); v.eres = eres; v.esrc = esrc; v.eaf = eaf; v.elf = elf;
    tbl.push_back(v);
  endtask

  initial begin
    in_t s;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rob_id = '0; bus.alu_res = '0;
    bus.lsb_valid = 1'b0; bus.lsb_rob_id = '0; bus.lsb_res = '0;

    //   rst rdy fl | av aid ares      | lv lid lres      | ev eid eres      src af lf
    add(1, 1, 0,  0,  0, 32'h0,     0,  0, 32'h0,     0,  0, 32'h0,     0, 0, 0);
    add(0, 1, 0,  1,  3, 32'h11,    0,  0, 32'h0,     1,  3, 32'h11,    0, 0, 0);
    add(0, 1, 0,  0,  0, 32'h0,     0,  0, 32'h0,     0,  3, 32'h11,    0, 0, 0);
    add(1, 1, 0,  0,  0, 32'h0,     0,  0, 32'h0,     0,  0, 32'h0,     0, 0, 0);
    add(0, 1, 0,  1,  4, 32'h44,    1,  5, 32'h55,    1,  4, 32'h44,    0, 0, 0);
    add(0, 1, 0,  0,  0, 32'h0,     0,  0, 32'h0,     1,  5, 32'h55,    1, 0, 0);
    add(0, 1, 0,  0,  0, 32'h0,     0,  0, 32'h0,     0,  5, 32'h55,    1, 0, 0);
    // both sources saturated, each held off while its FIFO is full
    add(0, 1, 0,  1,  6, 32'hA006,  1,  7, 32'hB007,  1,  6, 32'hA006,  0, 0, 0);
    add(0, 1, 0,  1,  8, 32'hA008,  1,  9, 32'hB009,  1,  7, 32'hB007,  1, 0, 0);
    add(0, 1, 0,  1, 10, 32'hA00A,  1, 11, 32'hB00B,  1,  8, 32'hA008,  0, 0, 1);
    add(0, 1, 0,  1, 12, 32'hA00C,  0,  0, 32'h0,     1,  9, 32'hB009,  1, 1, 0);
    add(0, 1, 0,  0,  0, 32'h0,     1, 13, 32'hB00D,  1, 10, 32'hA00A,  0, 0, 1);
    add(0, 1, 0,  1, 14, 32'hA00E,  0,  0, 32'h0,     1, 11, 32'hB00B,  1, 1, 0);
    add(0, 1, 0,  0,  0, 32'h0,     0,  0, 32'h0,     1, 12, 32'hA00C,  0, 0, 0);
    add(0, 1, 0,  0,  0, 32'h0,     0,  0, 32'h0,     1, 13, 32'hB00D,  1, 0, 0);
    add(0, 1, 0,  0,  0, 32'h0,     0,  0, 32'h0,     1, 14, 32'hA00E,  0, 0, 0);
    add(0, 1, 0,  0,  0, 32'h0,     0,  0, 32'h0,     0, 14, 32'hA00E,  0, 0, 0);
    // fill the LSB FIFO, then flush
    add(0, 1, 0,  1, 16, 32'hA010,  1, 17, 32'hB011,  1, 17, 32'hB011,  1, 0, 0);
    add(0, 1, 0,  1, 18, 32'hA012,  1, 19, 32'hB013,  1, 16, 32'hA010,  0, 0, 0);
    add(0, 1, 0,  1, 20, 32'hA014,  1, 21, 32'hB015,  1, 19, 32'hB013,  1, 1, 0);
    add(0, 1, 0,  0,  0, 32'h0,     1, 23, 32'hB017,  1, 18, 32'hA012,  0, 0, 1);
    add(0, 1, 1,  0,  0, 32'h0,     0,  0, 32'h0,     0, 18, 32'hA012,  0, 0, 0);
    add(0, 1, 0,  1,  7, 32'h77,    0,  0, 32'h0,     1,  7, 32'h77,    0, 0, 0);
    // null tag inputs are dropped
    add(0, 1, 0,  1,  0, 32'hDEAD,  1,  0, 32'hBEEF,  0,  7, 32'h77,    0, 0, 0);
    add(0, 1, 0,  0,  0, 32'h0,     0,  0, 32'h0,     0,  7, 32'h77,    0, 0, 0);
    // backlog frozen by rdy=0, then drains
    add(0, 1, 0,  1, 11, 32'hA00B,  1, 13, 32'hB00D,  1, 13, 32'hB00D,  1, 0, 0);
    add(0, 1, 0,  1, 12, 32'hA00C,  1,  9, 32'hB009,  1, 11, 32'hA00B,  0, 0, 0);
    add(0, 1, 0,  0,  0, 32'h0,     0,  0, 32'h0,     1,  9, 32'hB009,  1, 0, 0);
    add(0, 0, 0,  1, 20, 32'hA014,  1, 21, 32'hB015,  1,  9, 32'hB009,  1, 0, 0);
    add(0, 0, 0,  1, 20, 32'hA014,  1, 21, 32'hB015,  1,  9, 32'hB009,  1, 0, 0);
    add(0, 0, 1,  1, 20, 32'hA014,  1, 21, 32'hB015,  1,  9, 32'hB009,  1, 0, 0);
    add(0, 1, 0,  0,  0, 32'h0,     0,  0, 32'h0,     1, 12, 32'hA00C,  0, 0, 0);
    add(0, 1, 0,  0,  0, 32'h0,     0,  0, 32'h0,     0, 12, 32'hA00C,  0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].i);
      check($sformatf("vec%0d cdb_valid", i), 32'(bus.cdb_valid), 32'(tbl[i].ev));
      check($sformatf("vec%0d cdb_rob_id", i), 32'(bus.cdb_rob_id), 32'(tbl[i].eid));
      check($sformatf("vec%0d cdb_res", i), bus.cdb_res, tbl[i].eres);
      check($sformatf("vec%0d cdb_src", i), 32'(bus.cdb_src), 32'(tbl[i].esrc));
      check($sformatf("vec%0d alu_full", i), 32'(bus.alu_full), 32'(tbl[i].eaf));
      check($sformatf("vec%0d lsb_full", i), 32'(bus.lsb_full), 32'(tbl[i].elf));
    end

    for (int c = 0; c < 600; c++) begin
      s.rst   = ($urandom_range(0, 149) == 0);
      s.rdy   = ($urandom_range(0, 7) != 0);
      s.flush = ($urandom_range(0, 39) == 0);
      s.av    = ($urandom_range(0, 2) != 0) && (mq_a.size() < DEPTH);
      s.aid   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s.ares  = $urandom;
      s.lv    = ($urandom_range(0, 2) != 0) && (mq_l.size() < DEPTH);
      s.lid   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s.lres  = $urandom;
      step(s);
      check($sformatf("rnd%0d cdb_valid", c), 32'(bus.cdb_valid), 32'(m_cv));
      check($sformatf("rnd%0d cdb_rob_id", c), 32'(bus.cdb_rob_id), 32'(m_id));
      check($sformatf("rnd%0d cdb_res", c), bus.cdb_res, m_res);
      check($sformatf("rnd%0d cdb_src", c), 32'(bus.cdb_src), 32'(m_src));
      check($sformatf("rnd%0d alu_full", c), 32'(bus.alu_full), 32'(mq_a.size() == DEPTH));
      check($sformatf("rnd%0d lsb_full", c), 32'(bus.lsb_full), 32'(mq_l.size() == DEPTH));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
